pipe4_alu_fwd: RTL

Parametrised single-clock successor to the two-phase 4-stage register/ALU/memory pipeline. Each issued instruction reads two source registers, executes an ALU operation, writes the result to a destination register and then to a data memory word. It adds an issue valid, operand forwarding for back-to-back dependent instructions, illegal-op nullification, synchronous reset and debug read ports. It sits as the execution datapath under the instruction sequencer.

---
 rtl/pipe4_alu_pkg.sv | 34 +++
 rtl/pipe4_alu_core.sv | 36 +++
 rtl/pipe4_alu_fwd.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pipe4_alu_pkg.sv
// Shared definitions for the 4-stage ALU/regbank/memory pipeline:
// operation codes, the illegal-code range and default widths.
package pipe4_alu_pkg;

   localparam int DEF_DATA_W    = 16;
   localparam int DEF_REG_N     = 16;
   localparam int DEF_MEM_DEPTH = 256;

   typedef enum logic [3:0] {
      FUNC_ADD  = 4'd0,
      FUNC_SUB  = 4'd1,
      FUNC_MUL  = 4'd2,
      FUNC_SELA = 4'd3,
      FUNC_SELB = 4'd4,
      FUNC_AND  = 4'd5,
      FUNC_OR   = 4'd6,
      FUNC_XOR  = 4'd7,
      FUNC_NEGA = 4'd8,
      FUNC_NEGB = 4'd9,
      FUNC_SRL  = 4'd10,
      FUNC_SLA  = 4'd11
   } func_e;

   // Codes 12..15 are reserved and nullify the instruction.
   localparam logic [3:0] FUNC_ILLEGAL_LO = 4'd12;

   // Control half of every stage register; the data fields depend on
   // the instance widths and are declared alongside it in the top.
   typedef struct packed {
      logic       valid;
      logic [3:0] func;
   } stage_ctl_t;

endpackage

// File: rtl/pipe4_alu_core.sv
// Purely combinational ALU: all arithmetic wraps modulo 2^DATA_W.
// Illegal codes produce result 0 with the illegal flag set.
module pipe4_alu_core
   import pipe4_alu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        func,
   output logic [DATA_W-1:0] result,
   output logic              illegal
);

   // Operation decode; the default arm covers the reserved range.
   always_comb begin
      result  = '0;
      illegal = (func >= FUNC_ILLEGAL_LO);
      case (func)
         FUNC_ADD:  result = a + b;
         FUNC_SUB:  result = a - b;
         FUNC_MUL:  result = a * b;
         FUNC_SELA: result = a;
         FUNC_SELB: result = b;
         FUNC_AND:  result = a & b;
         FUNC_OR:   result = a | b;
         FUNC_XOR:  result = a ^ b;
         FUNC_NEGA: result = -a;
         FUNC_NEGB: result = -b;
         FUNC_SRL:  result = a >> 1;
         FUNC_SLA:  result = a << 1;
         default:   result = '0;
      endcase
   end

endmodule

// File: rtl/pipe4_alu_fwd.sv
// Single-clock 4-stage execution datapath: S1 operand capture with
// forwarding, S2 registered ALU result, S3 regbank write, S4 memory write.
// Handshake: in_valid qualifies the issue fields for exactly one cycle; there
// is no back-pressure, every valid instruction is accepted, and z_valid marks
// the single cycle in which z (and illegal) belong to that instruction.
module pipe4_alu_fwd
   import pipe4_alu_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int REG_N     = DEF_REG_N,
   parameter int MEM_DEPTH = DEF_MEM_DEPTH,
   localparam int REG_AW   = $clog2(REG_N),
   localparam int MEM_AW   = $clog2(MEM_DEPTH)
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   input  logic [REG_AW-1:0] rd,
   input  logic [3:0]        func,
   input  logic [MEM_AW-1:0] addr,
   output logic [DATA_W-1:0] z,
   output logic              z_valid,
   output logic              illegal,
   input  logic [REG_AW-1:0] dbg_reg_addr,
   output logic [DATA_W-1:0] dbg_reg_data,
   input  logic [MEM_AW-1:0] dbg_mem_addr,
   output logic [DATA_W-1:0] dbg_mem_data
);

   typedef struct packed {
      stage_ctl_t        ctl;
      logic [REG_AW-1:0] rd;
      logic [MEM_AW-1:0] addr;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } s1_t;

   typedef struct packed {
      logic              valid;
      logic              illegal;
      logic [REG_AW-1:0] rd;
      logic [MEM_AW-1:0] addr;
      logic [DATA_W-1:0] result;
   } s2_t;

   typedef struct packed {
      logic              valid;
      logic [MEM_AW-1:0] addr;
      logic [DATA_W-1:0] result;
   } s3_t;

   s1_t s1;
   s2_t s2;
   s3_t s3;

   logic [DATA_W-1:0] regbank [REG_N];
   logic [DATA_W-1:0] mem     [MEM_DEPTH];

   logic [DATA_W-1:0] alu_res;
   logic              alu_ill;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              s1_fwd_ok;
   logic              s2_fwd_ok;

   pipe4_alu_core #(.DATA_W(DATA_W)) u_core (
      .a       (s1.a),
      .b       (s1.b),
      .func    (s1.ctl.func),
      .result  (alu_res),
      .illegal (alu_ill)
   );

   assign s1_fwd_ok = s1.ctl.valid && !alu_ill;
   assign s2_fwd_ok = s2.valid && !s2.illegal;

   // Operand select, youngest producer first: S1 ALU output, then S2 z, then
   // regbank. S2 must forward because its regbank write lands at this edge.
   always_comb begin
      op_a = regbank[rs1];
      op_b = regbank[rs2];
      if (s1_fwd_ok && s1.rd == rs1)      op_a = alu_res;
      else if (s2_fwd_ok && s2.rd == rs1) op_a = s2.result;
      if (s1_fwd_ok && s1.rd == rs2)      op_b = alu_res;
      else if (s2_fwd_ok && s2.rd == rs2) op_b = s2.result;
   end

   // Stage registers S1..S3; reset drops every in-flight instruction.
   always_ff @(posedge clk1) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1.ctl.valid <= in_valid;
         s1.ctl.func  <= func;
         s1.rd        <= rd;
         s1.addr      <= addr;
         s1.a         <= op_a;
         s1.b         <= op_b;

         s2.valid     <= s1.ctl.valid;
         s2.illegal   <= s1.ctl.valid && alu_ill;
         s2.rd        <= s1.rd;
         s2.addr      <= s1.addr;
         s2.result    <= (s1.ctl.valid && !alu_ill) ? alu_res : '0;

         s3.valid     <= s2_fwd_ok;
         s3.addr      <= s2.addr;
         s3.result    <= s2.result;
      end
   end

   // Regbank: identity contents on reset, otherwise the S2 result is retired.
   always_ff @(posedge clk1) begin
      if (rst) begin
         for (int k = 0; k < REG_N; k++) regbank[k] <= DATA_W'(k);
      end else if (s2_fwd_ok) begin
         regbank[s2.rd] <= s2.result;
      end
   end

   // Data memory keeps its contents through reset; reset only blocks the write.
   always_ff @(posedge clk1) begin
      if (!rst && s3.valid) mem[s3.addr] <= s3.result;
   end

   assign z            = s2.result;
   assign z_valid      = s2.valid;
   assign illegal      = s2.illegal;
   assign dbg_reg_data = regbank[dbg_reg_addr];
   assign dbg_mem_data = mem[dbg_mem_addr];

endmodule
